uart_tx_feeder: RTL

//  Byte FIFO and launch sequencer directly upstream of Uart8Transmitter.

---
 rtl/uart_tx_feeder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO and launch sequencer that sits directly in front of a UART
//   transmitter (start/busy/done handshake). Game logic may push one byte per
//   cycle. The feeder launches one frame at a time and flags dropped pushes
//   and frames whose done never came back. Runs on the transmitter's clock.
//
// Ports
//   clk          baud-rate clock shared with the transmitter
//   rst          asynchronous, active-high reset
//   wr_en        push wr_data this cycle
//   wr_data      byte to queue
//   full         count == DEPTH
//   empty        count == 0
//   count        bytes queued, not counting the byte in flight
//   overflow     sticky: a push was dropped while full
//   timeout_err  sticky: a frame saw no tx_done within TIMEOUT cycles
//   tx_en        transmitter enable, 1 from the first edge after reset
//   tx_start     single-cycle launch pulse to the transmitter
//   tx_data      head byte, valid while tx_start=1 (0 otherwise)
//   tx_busy      transmitter busy
//   tx_done      transmitter frame done
module uart_tx_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout_err,
  output logic                     tx_en,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [TW-1:0]   r_timer;
  logic            r_low_seen;
  logic            r_overflow;
  logic            r_timeout_err;
  logic            r_tx_en;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_timer_hit;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = wr_en && !w_full;
  assign w_pop       = (r_state == S_LAUNCH);
  // Done has priority: a done on the last allowed cycle still completes the frame.
  assign w_timer_hit = (r_state == S_WAIT) && !tx_done &&
                       (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Busy lags start by a cycle, so two consecutive low samples are needed
      // before the transmitter can be trusted to be idle.
      S_SYNC:   if (!tx_busy && r_low_seen) w_state_nxt = S_IDLE;
      S_IDLE:   if (!w_empty) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done)          w_state_nxt = S_IDLE;
        else if (w_timer_hit) w_state_nxt = S_SYNC;
      end
      default:  w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_SYNC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_timer       <= '0;
      r_low_seen    <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tx_en       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx_en <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      // A pop in the same cycle does not rescue a push that arrived while full.
      if (wr_en && w_full) r_overflow    <= 1'b1;
      if (w_timer_hit)     r_timeout_err <= 1'b1;

      if (r_state == S_LAUNCH)    r_timer <= '0;
      else if (r_state == S_WAIT) r_timer <= r_timer + TW'(1);

      // Only meaningful inside SYNC; cleared elsewhere so each SYNC entry
      // starts counting busy-low samples from zero.
      if (r_state == S_SYNC) r_low_seen <= !tx_busy;
      else                   r_low_seen <= 1'b0;
    end
  end

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;
  assign tx_en       = r_tx_en;
  assign tx_start    = (r_state == S_LAUNCH);
  assign tx_data     = tx_start ? r_mem[r_rd_ptr] : 8'h00;

endmodule
